tcam_lookup_pipe: RTL

TCAM_LOOKUP_PIPE -- requirements
Module: tcam_lookup_pipe

---
 rtl/tcam_lookup_pipe_if.sv | 50 +++++
 rtl/tcam_lookup_pipe.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tcam_lookup_pipe_if.sv
// tcam_lookup_pipe_if: lookup request, result, table write and statistics
// signals of tcam_lookup_pipe, bundled with master/slave views.
interface tcam_lookup_pipe_if #(
   parameter int KEY_W = 256,
   parameter int PHV_W = 1024,
   parameter int DEPTH = 16,
   parameter int ACT_W = 25
);
   localparam int IDX_W = $clog2(DEPTH);

   // lookup request channel
   logic             in_valid;
   logic             in_ready;
   logic [KEY_W-1:0] in_key;
   logic [PHV_W-1:0] in_phv;

   // result channel
   logic             out_valid;
   logic             out_ready;
   logic [ACT_W-1:0] out_action;
   logic             out_hit;
   logic [IDX_W-1:0] out_idx;
   logic [PHV_W-1:0] out_phv;

   // table write channel
   logic             wr_en;
   logic [IDX_W-1:0] wr_addr;
   logic [KEY_W-1:0] wr_key;
   logic [KEY_W-1:0] wr_mask;
   logic [ACT_W-1:0] wr_act;
   logic             wr_vld;

   // statistics
   logic [31:0]      hit_cnt;
   logic [31:0]      miss_cnt;

   modport slave (
      input  in_valid, in_key, in_phv, out_ready,
             wr_en, wr_addr, wr_key, wr_mask, wr_act, wr_vld,
      output in_ready, out_valid, out_action, out_hit, out_idx, out_phv,
             hit_cnt, miss_cnt
   );

   modport master (
      output in_valid, in_key, in_phv, out_ready,
             wr_en, wr_addr, wr_key, wr_mask, wr_act, wr_vld,
      input  in_ready, out_valid, out_action, out_hit, out_idx, out_phv,
             hit_cnt, miss_cnt
   );
endinterface

// File: rtl/tcam_lookup_pipe.sv
// tcam_lookup_pipe: DEPTH-entry ternary match table with a two-register
// lookup pipeline (S1 = match result, S2 = output register). Lowest matching
// index wins; misses return DEFAULT_ACT. The header vector rides along with
// its result unmodified.
// Optional feature: define TCAM_LOOKUP_STATS_EN to build saturating hit/miss
// counters; without it hit_cnt/miss_cnt are tied to zero.
module tcam_lookup_pipe #(
   parameter int               KEY_W       = 256,
   parameter int               PHV_W       = 1024,
   parameter int               DEPTH       = 16,
   parameter int               ACT_W       = 25,
   parameter logic [ACT_W-1:0] DEFAULT_ACT = 25'h3f
) (
   input  logic                axi_clk,
   input  logic                aresetn,
   tcam_lookup_pipe_if.slave   bus
);
   localparam int IDX_W = $clog2(DEPTH);

   // table storage
   logic [KEY_W-1:0] key_r  [DEPTH];
   logic [KEY_W-1:0] mask_r [DEPTH];
   logic [ACT_W-1:0] act_r  [DEPTH];
   logic [DEPTH-1:0] vld_r;

   // stage S1
   logic             s1_vld_r;
   logic             s1_hit_r;
   logic [IDX_W-1:0] s1_idx_r;
   logic [ACT_W-1:0] s1_act_r;
   logic [PHV_W-1:0] s1_phv_r;

   // stage S2 (output register)
   logic             s2_vld_r;
   logic             s2_hit_r;
   logic [IDX_W-1:0] s2_idx_r;
   logic [ACT_W-1:0] s2_act_r;
   logic [PHV_W-1:0] s2_phv_r;

   logic [DEPTH-1:0] match_s;
   logic             lk_hit_s;
   logic [IDX_W-1:0] lk_idx_s;
   logic [ACT_W-1:0] lk_act_s;
   logic             s2_adv_s;
   logic             s1_adv_s;
   logic             in_ready_s;
   logic             accept_s;

   // S2 can load when empty or when its content leaves this cycle; S1 can
   // load when empty or when it moves into S2. Reset forces ready low.
   assign s2_adv_s   = !s2_vld_r || bus.out_ready;
   assign s1_adv_s   = !s1_vld_r || s2_adv_s;
   assign in_ready_s = aresetn && s1_adv_s;
   assign accept_s   = bus.in_valid && in_ready_s;

   assign bus.in_ready   = in_ready_s;
   assign bus.out_valid  = s2_vld_r;
   assign bus.out_hit    = s2_hit_r;
   assign bus.out_idx    = s2_idx_r;
   assign bus.out_action = s2_act_r;
   assign bus.out_phv    = s2_phv_r;

   // Ternary compare of the request key against every valid entry
   always_comb begin
      match_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         match_s[i] = vld_r[i] && (((bus.in_key ^ key_r[i]) & mask_r[i]) == {KEY_W{1'b0}});
      end
   end

   // Priority select: scan from the top so the lowest matching index wins
   always_comb begin
      lk_hit_s = 1'b0;
      lk_idx_s = {IDX_W{1'b0}};
      lk_act_s = DEFAULT_ACT;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         lk_hit_s = match_s[i] | lk_hit_s;
         lk_idx_s = match_s[i] ? IDX_W'(i) : lk_idx_s;
         lk_act_s = match_s[i] ? act_r[i]  : lk_act_s;
      end
   end

   // Table write; a lookup accepted on the same edge already used old contents
   always_ff @(posedge axi_clk or negedge aresetn) begin
      if (!aresetn) begin
         vld_r <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            key_r[i]  <= {KEY_W{1'b0}};
            mask_r[i] <= {KEY_W{1'b0}};
            act_r[i]  <= {ACT_W{1'b0}};
         end
      end else if (bus.wr_en) begin
         key_r[bus.wr_addr]  <= bus.wr_key;
         mask_r[bus.wr_addr] <= bus.wr_mask;
         act_r[bus.wr_addr]  <= bus.wr_act;
         vld_r[bus.wr_addr]  <= bus.wr_vld;
      end
   end

   // Stage S1: capture lookup result and header vector on accept
   always_ff @(posedge axi_clk or negedge aresetn) begin
      if (!aresetn) begin
         s1_vld_r <= 1'b0;
         s1_hit_r <= 1'b0;
         s1_idx_r <= {IDX_W{1'b0}};
         s1_act_r <= {ACT_W{1'b0}};
         s1_phv_r <= {PHV_W{1'b0}};
      end else if (s1_adv_s) begin
         s1_vld_r <= accept_s;
         if (accept_s) begin
            s1_hit_r <= lk_hit_s;
            s1_idx_r <= lk_idx_s;
            s1_act_r <= lk_act_s;
            s1_phv_r <= bus.in_phv;
         end
      end
   end

   // Stage S2: output register, frozen while the consumer stalls
   always_ff @(posedge axi_clk or negedge aresetn) begin
      if (!aresetn) begin
         s2_vld_r <= 1'b0;
         s2_hit_r <= 1'b0;
         s2_idx_r <= {IDX_W{1'b0}};
         s2_act_r <= {ACT_W{1'b0}};
         s2_phv_r <= {PHV_W{1'b0}};
      end else if (s2_adv_s) begin
         s2_vld_r <= s1_vld_r;
         if (s1_vld_r) begin
            s2_hit_r <= s1_hit_r;
            s2_idx_r <= s1_idx_r;
            s2_act_r <= s1_act_r;
            s2_phv_r <= s1_phv_r;
         end
      end
   end

`ifdef TCAM_LOOKUP_STATS_EN
   logic [31:0] hit_cnt_r;
   logic [31:0] miss_cnt_r;

   // Count delivered results by outcome, saturating at all-ones
   always_ff @(posedge axi_clk or negedge aresetn) begin
      if (!aresetn) begin
         hit_cnt_r  <= 32'h0;
         miss_cnt_r <= 32'h0;
      end else if (s2_vld_r && bus.out_ready) begin
         if (s2_hit_r) begin
            if (hit_cnt_r != 32'hFFFF_FFFF) begin
               hit_cnt_r <= hit_cnt_r + 32'd1;
            end
         end else begin
            if (miss_cnt_r != 32'hFFFF_FFFF) begin
               miss_cnt_r <= miss_cnt_r + 32'd1;
            end
         end
      end
   end

   assign bus.hit_cnt  = hit_cnt_r;
   assign bus.miss_cnt = miss_cnt_r;
`else
   assign bus.hit_cnt  = 32'h0;
   assign bus.miss_cnt = 32'h0;
`endif

endmodule
